// File: rtl/instr_cache_controller.sv
// Instruction cache hit/miss and line-fill controller.
// Hits return data combinationally. A miss fills the aligned line from main memory and then replays the fetch.
module instr_cache_controller #(
    parameter int BLOCKWORDS = 4,
    parameter int TAGBITS    = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pcf,
    output logic [31:0]        instrf,
    output logic               stallf,
    output logic [31:0]        ca,
    input  logic               crv,
    input  logic [TAGBITS-1:0] crtag,
    input  logic [31:0]        crd,
    output logic               cwe,
    output logic [31:0]        cwd,
    output logic               mreq,
    output logic [31:0]        maddr,
    input  logic               mack,
    input  logic [31:0]        mrdata
);
    localparam int OFFB = $clog2(BLOCKWORDS);

    typedef enum logic [1:0] {
        READY = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     missaddr_q, missaddr_d;
    logic [OFFB-1:0] cnt_q, cnt_d;

    logic            hit_s;
    logic            last_s;
    logic [31:0]     fill_addr_s;
    logic [31:0]     instrf_s;
    logic            stallf_s;
    logic [31:0]     ca_s;
    logic            cwe_s;
    logic [31:0]     cwd_s;
    logic            mreq_s;
    logic [31:0]     maddr_s;

    assign hit_s       = crv && (crtag == pcf[31:32-TAGBITS]);
    assign last_s      = (cnt_q == OFFB'(BLOCKWORDS - 1));
    // The fill always walks the line from its base, whatever word missed.
    assign fill_addr_s = {missaddr_q[31:OFFB+2], cnt_q, 2'b00};

    // Next-state and output decode for the hit/fill sequencer
    always_comb begin
        state_d    = state_q;
        missaddr_d = missaddr_q;
        cnt_d      = cnt_q;
        instrf_s   = 32'h0000_0000;
        stallf_s   = 1'b1;
        ca_s       = pcf;
        cwe_s      = 1'b0;
        cwd_s      = 32'h0000_0000;
        mreq_s     = 1'b0;
        maddr_s    = 32'h0000_0000;
        case (state_q)
            READY: begin
                ca_s = pcf;
                if (hit_s) begin
                    instrf_s = crd;
                    stallf_s = 1'b0;
                end else begin
                    missaddr_d = pcf;
                    cnt_d      = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                mreq_s  = 1'b1;
                maddr_s = fill_addr_s;
                ca_s    = fill_addr_s;
                cwd_s   = mrdata;
                cwe_s   = mack;
                if (mack) begin
                    if (last_s) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + OFFB'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DONE: begin
                ca_s    = missaddr_q;
                state_d = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    // State, miss address and fill counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= READY;
            missaddr_q <= 32'h0000_0000;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            missaddr_q <= missaddr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Reset must kill an in-flight request and hold fetch stalled without waiting for a clock.
    assign stallf = reset ? 1'b1         : stallf_s;
    assign instrf = reset ? 32'h0000_0000 : instrf_s;
    assign ca     = reset ? pcf          : ca_s;
    assign cwe    = reset ? 1'b0         : cwe_s;
    assign cwd    = reset ? 32'h0000_0000 : cwd_s;
    assign mreq   = reset ? 1'b0         : mreq_s;
    assign maddr  = reset ? 32'h0000_0000 : maddr_s;

endmodule

// File: tb/tb_instr_cache_controller.sv
// Self-checking bench for instr_cache_controller: cache memory and main memory models,
// a behavioural cache-content model and directed plus randomized fetch sequences.
module tb_instr_cache_controller;
    localparam int BW = 4;
    localparam int TB = 14;

    logic          clk;
    logic          reset;
    logic [31:0]   pcf;
    logic [31:0]   instrf;
    logic          stallf;
    logic [31:0]   ca;
    logic          crv;
    logic [TB-1:0] crtag;
    logic [31:0]   crd;
    logic          cwe;
    logic [31:0]   cwd;
    logic          mreq;
    logic [31:0]   maddr;
    logic          mack;
    logic [31:0]   mrdata;

    instr_cache_controller #(.BLOCKWORDS(BW), .TAGBITS(TB)) dut (
        .clk(clk), .reset(reset), .pcf(pcf), .instrf(instrf), .stallf(stallf),
        .ca(ca), .crv(crv), .crtag(crtag), .crd(crd), .cwe(cwe), .cwd(cwd),
        .mreq(mreq), .maddr(maddr), .mack(mack), .mrdata(mrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Cache memory: combinational read at ca, write on clock edge when cwe.
    bit          cm_v   [0:65535];
    logic [13:0] cm_tag [0:65535];
    logic [31:0] cm_d   [0:65535];

    assign crv   = cm_v[ca[17:2]];
    assign crtag = cm_tag[ca[17:2]];
    assign crd   = cm_d[ca[17:2]];

    initial begin
        for (int i = 0; i < 65536; i++) begin
            cm_v[i]   = 1'b0;
            cm_tag[i] = 14'h0000;
            cm_d[i]   = 32'h0000_0000;
        end
        cm_v[4]   = 1'b1;
        cm_tag[4] = 14'h0000;
        cm_d[4]   = 32'hE3A0_1005;
        forever begin
            @(posedge clk);
            if (cwe === 1'b1) begin
                cm_v[ca[17:2]]   <= 1'b1;
                cm_tag[ca[17:2]] <= ca[31:18];
                cm_d[ca[17:2]]   <= cwd;
            end
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Main-memory responder
    bit toggle_mack = 1'b0;
    bit inject_late = 1'b0;
    bit rand_lat    = 1'b0;
    int fixed_lat   = 0;
    int waits_total = 0;
    int wait_left   = 0;

    function automatic int next_lat();
        return rand_lat ? int'($urandom_range(0, 2)) : fixed_lat;
    endfunction

    initial begin
        mack   = 1'b0;
        mrdata = 32'h0000_0000;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mack) begin
                mack   = ~mack;
                mrdata = $urandom;
            end else if (inject_late) begin
                mack   = 1'b1;
                mrdata = 32'hDEAD_BEEF;
            end else if (mreq === 1'b1) begin
                if (wait_left == 0) begin
                    mack      = 1'b1;
                    mrdata    = mem_word(maddr);
                    wait_left = next_lat();
                end else begin
                    mack        = 1'b0;
                    wait_left   = wait_left - 1;
                    waits_total = waits_total + 1;
                end
            end else begin
                mack      = 1'b0;
                wait_left = next_lat();
            end
        end
    end

    // Behavioural model of cache contents, keyed by word index.
    bit          model_v   [int];
    logic [13:0] model_tag [int];
    logic [31:0] model_d   [int];

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = int'(a[17:2]);
        return model_v.exists(idx) && (model_tag[idx] == a[31:18]);
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d);
        int idx;
        idx = int'(a[17:2]);
        model_v[idx]   = 1'b1;
        model_tag[idx] = a[31:18];
        model_d[idx]   = d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [31:0] seen_q [$];

    // One fetch, checked every cycle from issue until the instruction is delivered.
    task automatic fetch(input logic [31:0] addr, input int abort_k, input bit alt_pcf,
                         output int stalls, output bit was_hit);
        int          w0;
        int          k;
        logic [31:0] base;
        bit          done;
        stalls  = 0;
        was_hit = 1'b0;
        done    = 1'b0;
        k       = 0;
        seen_q.delete();
        base = addr & ~(32'(BW * 4) - 32'd1);
        @(posedge clk);
        #1 pcf = addr;
        w0 = waits_total;
        @(negedge clk);
        if (model_hit(addr)) begin
            was_hit = 1'b1;
            chk("hit_stallf", {31'd0, stallf}, 32'd0);
            chk("hit_instrf", instrf, model_d[int'(addr[17:2])]);
            chk("hit_mreq", {31'd0, mreq}, 32'd0);
            chk("hit_cwe", {31'd0, cwe}, 32'd0);
            return;
        end
        chk("miss_stallf", {31'd0, stallf}, 32'd1);
        chk("miss_instrf", instrf, 32'd0);
        chk("miss_mreq", {31'd0, mreq}, 32'd0);
        stalls = 1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (stallf === 1'b0) begin
                chk("replay_instrf", instrf, mem_word(addr));
                chk("fill_words", 32'(k), 32'(BW));
                chk("stall_cycles", 32'(stalls), 32'(BW + 2 + waits_total - w0));
                for (int j = 0; j < BW; j++) begin
                    model_store(base + 32'(4 * j), mem_word(base + 32'(4 * j)));
                end
                done = 1'b1;
            end else begin
                stalls = stalls + 1;
                chk("stall_instrf", instrf, 32'd0);
                if (mreq === 1'b1) begin
                    chk("fill_maddr", maddr, base + 32'(4 * k));
                    chk("fill_ca", ca, maddr);
                    chk("fill_cwe", {31'd0, cwe}, {31'd0, mack});
                    if (cwe === 1'b1) begin
                        chk("fill_cwd", cwd, mem_word(maddr));
                        seen_q.push_back(maddr);
                        k = k + 1;
                        if (k == abort_k) return;
                    end
                    if (alt_pcf && k == 1) pcf = 32'h0000_0100;
                    if (alt_pcf && k == 3) pcf = addr;
                end else begin
                    chk("done_ca", ca, addr);
                    chk("done_cwe", {31'd0, cwe}, 32'd0);
                    chk("done_words", 32'(k), 32'(BW));
                end
            end
        end
        if (!done) begin
            chk("fetch_timeout", 32'd1, 32'd0);
        end
    endtask

    int          st;
    bit          h;
    logic [31:0] exp_seq [4];
    logic [31:0] ra;

    initial begin
        reset = 1'b1;
        pcf   = 32'h0000_0010;
        model_store(32'h0000_0010, 32'hE3A0_1005);
        toggle_mack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_stallf", {31'd0, stallf}, 32'd1);
            chk("rst_mreq", {31'd0, mreq}, 32'd0);
            chk("rst_cwe", {31'd0, cwe}, 32'd0);
            chk("rst_maddr", maddr, 32'd0);
            chk("rst_instrf", instrf, 32'd0);
            chk("rst_ca", ca, pcf);
        end
        toggle_mack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, stallf}, 32'd0);
        chk("ready_instrf", instrf, 32'hE3A0_1005);

        fetch(32'h0000_0010, -1, 1'b0, st, h);
        chk("preload_hit", {31'd0, h}, 32'd1);

        fixed_lat = 0;
        fetch(32'h0004_0028, -1, 1'b0, st, h);
        chk("miss_stalls6", 32'(st), 32'd6);
        exp_seq[0] = 32'h0004_0020;
        exp_seq[1] = 32'h0004_0024;
        exp_seq[2] = 32'h0004_0028;
        exp_seq[3] = 32'h0004_002C;
        chk("miss_seq_len", 32'(seen_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen_q.size(); i++) begin
            chk("miss_seq_addr", seen_q[i], exp_seq[i]);
        end
        fetch(32'h0004_0020, -1, 1'b0, st, h);
        chk("line_now_hit", {31'd0, h}, 32'd1);

        fixed_lat = 3;
        fetch(32'h0008_0044, -1, 1'b0, st, h);
        chk("slow_stalls18", 32'(st), 32'd18);

        fixed_lat = 1;
        fetch(32'h000C_0050, -1, 1'b1, st, h);
        chk("altpcf_stalls", 32'(st), 32'd10);

        fixed_lat = 0;
        fetch(32'h0010_0060, 2, 1'b0, st, h);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_mreq", {31'd0, mreq}, 32'd0);
        chk("abort_stallf", {31'd0, stallf}, 32'd1);
        chk("abort_cwe", {31'd0, cwe}, 32'd0);
        chk("abort_maddr", maddr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_store(32'h0010_0060, mem_word(32'h0010_0060));
        model_store(32'h0010_0064, mem_word(32'h0010_0064));
        inject_late = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("late_mack_mreq", {31'd0, mreq}, 32'd0);
            chk("late_mack_cwe", {31'd0, cwe}, 32'd0);
        end
        inject_late = 1'b0;
        chk("abort_w3_invalid", {31'd0, cm_v[16'h001B]}, 32'd0);
        fetch(32'h0010_0060, -1, 1'b0, st, h);
        chk("abort_w0_hit", {31'd0, h}, 32'd1);
        fetch(32'h0010_0064, -1, 1'b0, st, h);
        chk("abort_w1_hit", {31'd0, h}, 32'd1);
        fetch(32'h0010_0068, -1, 1'b0, st, h);
        chk("abort_w2_miss", {31'd0, h}, 32'd0);

        rand_lat = 1'b1;
        for (int n = 0; n < 80; n++) begin
            ra = (32'($urandom_range(0, 3)) << 18) | (32'($urandom_range(0, 31)) << 2);
            fetch(ra, -1, 1'b0, st, h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
